instr_fetch_queue: RTL and testbench
====================================

Name: instr_fetch_queue

Overview:
- Producer side of the decoder's `instr` input.
- Issues sequential word fetches to instruction memory and buffers the returned words with their PCs in a FIFO.
- Presents one {pc, instr} per cycle to decode under a valid/ready handshake.
- Handles control-flow redirects from the branch/jump resolution logic by flushing the FIFO and discarding stale in-flight responses.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2. Also the cap on queued plus outstanding fetches.
- RESET_PC, 32'h0000_3000, first fetch address after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- redirect_valid  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch PC; bits[1:0] ignored (treated as 0).
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  word-aligned fetch address.
- imem_resp_valid  in  1  response valid; one per accepted request, in order, ≥1 cycle after acceptance.
- imem_resp_data  in  32  instruction word.
- out_valid  out  1  out_pc/out_instr valid to decoder.
- out_ready  in  1  decoder consumes.
- out_instr  out  32  instruction at FIFO head.
- out_pc  out  32  PC of out_instr.
- inflight_cnt  out  $clog2(DEPTH+1)  outstanding requests (debug).

Behaviour:
- Reset (rst=1 at posedge):
  - fetch_pc=RESET_PC, resp_pc=RESET_PC.
  - count=0, inflight=0, discard=0, FIFO pointers=0.
  - imem_req_valid=0, out_valid=0, out_instr=0, out_pc=0, inflight_cnt=0 while rst is high.
- Reset mid-operation: instruction memory shares rst and drops pending requests; no response for a pre-reset request arrives after reset.
- Request issue:
  - imem_req_valid = !rst && !redirect_valid && (count + inflight) < DEPTH.
  - imem_req_addr = fetch_pc.
  - On accept: fetch_pc += 4 (wraps mod 2^32); inflight += 1.
- Response:
  - Every imem_resp_valid decrements inflight. Accept and response in the same cycle leave inflight unchanged.
  - If discard>0: discard -= 1; the word is dropped.
  - Else: push {resp_pc, imem_resp_data}; resp_pc += 4.
  - Overflow cannot occur, because of the credit rule on issue.
- Output:
  - out_valid = (count>0) && !redirect_valid.
  - out_instr/out_pc = head entry when out_valid, else 0.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle: count unchanged. Full-and-pop is legal; a push into full is impossible.
- Redirect (redirect_valid=1 at posedge, highest priority after rst):
  - FIFO flushed: count=0, pointers reset.
  - No request issued and no pop that cycle.
  - A response arriving that same cycle is dropped.
  - discard = inflight after that cycle's response decrement, i.e. inflight − resp_this_cycle.
  - fetch_pc = resp_pc = {redirect_pc[31:2], 2'b00}.
  - Fetch resumes the next cycle.
- Back-to-back redirects: each recomputes discard from the current inflight. Earlier stale responses are still counted, so never double-count.
- Invariant: discard ≤ inflight ≤ DEPTH.
- Latency: a response arriving at edge N yields out_valid in cycle N+1 (registered FIFO).
- Throughput: 1 instr/cycle sustained with single-cycle memory and DEPTH≥2.

Optional Feature:
- Macro: IFQ_BYPASS_EN.
- With the macro defined, when count==0, discard==0, !redirect_valid and imem_resp_valid:
  - out_valid=1 combinationally, with out_instr=imem_resp_data and out_pc=resp_pc.
  - If out_ready, the word is consumed without entering the FIFO (zero-cycle latency); resp_pc += 4.
  - Otherwise it is pushed as normal.
- Without the macro: strict 1-cycle latency through the FIFO; no combinational path from imem_resp_* to out_*.

Test Plan:
- Reset then stream (memory ready=1, 1-cycle latency, out_ready=1):
  - Requests at 0x3000, 0x3004, 0x3008…
  - out_pc sequence 0x3000, 0x3004… one per cycle after fill.
  - out_instr matches memory contents.
- Backpressure (out_ready=0 for 10 cycles):
  - Issue stops when count+inflight=4.
  - Exactly 4 entries are held.
  - Resuming out_ready=1 drains 0x3000..0x300C in order, with no loss or duplication.
- Redirect with 2 in flight (memory latency 3):
  - redirect_pc=0x4000 → next 2 responses dropped.
  - First out_pc=0x4000.
  - No 0x30xx PC appears after the redirect.
- Redirect with bits[1:0]=2'b11 (0x4003) → imem_req_addr=0x4000, out_pc=0x4000.
- Redirect coinciding with out_valid&&out_ready and imem_resp_valid:
  - out_valid=0 that cycle.
  - Response dropped.
  - FIFO empty next cycle.
  - inflight_cnt consistent with outstanding requests.
- Wrap: redirect_pc=0xFFFF_FFFC → out_pc 0xFFFF_FFFC then 0x0000_0000.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues sequential word fetches, buffers {pc, instr} responses in a FIFO,
// and handles redirects by flushing and discarding stale responses. Optional macro: IFQ_BYPASS_EN.
module instr_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         redirect_valid,
    input  logic [31:0]                  redirect_pc,
    output logic                         imem_req_valid,
    input  logic                         imem_req_ready,
    output logic [31:0]                  imem_req_addr,
    input  logic                         imem_resp_valid,
    input  logic [31:0]                  imem_resp_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  out_instr,
    output logic [31:0]                  out_pc,
    output logic [$clog2(DEPTH+1)-1:0]   inflight_cnt
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0] discard_q, discard_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]      fifo_pc_q [DEPTH];
    logic [31:0]      fifo_pc_d [DEPTH];
    logic [31:0]      fifo_instr_q [DEPTH];
    logic [31:0]      fifo_instr_d [DEPTH];

    logic             req_fire_s;
    logic             keep_s;
    logic             bypass_s;
    logic             push_s;
    logic             pop_s;
    logic [SUM_W-1:0] credit_used_s;

    // Queued entries plus outstanding fetches never exceed DEPTH, so a push can never overflow.
    assign credit_used_s  = SUM_W'(count_q) + SUM_W'(inflight_q);
    assign imem_req_valid = !rst && !redirect_valid && (credit_used_s < SUM_W'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire_s     = imem_req_valid && imem_req_ready;
    assign keep_s         = imem_resp_valid && !redirect_valid && (discard_q == {CNT_W{1'b0}});
    assign inflight_cnt   = rst ? {CNT_W{1'b0}} : inflight_q;

`ifdef IFQ_BYPASS_EN
    assign bypass_s = !rst && keep_s && (count_q == {CNT_W{1'b0}});
`else
    assign bypass_s = 1'b0;
`endif

    assign pop_s  = out_valid && out_ready && !bypass_s;
    assign push_s = keep_s && !(bypass_s && out_ready);

    // Output mux: bypassed response, FIFO head, or zeros.
    always_comb begin
        out_valid = 1'b0;
        out_pc    = 32'h0000_0000;
        out_instr = 32'h0000_0000;
        if (bypass_s) begin
            out_valid = 1'b1;
            out_pc    = resp_pc_q;
            out_instr = imem_resp_data;
        end else if (!rst && !redirect_valid && (count_q != {CNT_W{1'b0}})) begin
            out_valid = 1'b1;
            out_pc    = fifo_pc_q[rd_ptr_q];
            out_instr = fifo_instr_q[rd_ptr_q];
        end else begin
            out_valid = 1'b0;
        end
    end

    // Next-state logic for fetch PCs, credit counters and FIFO.
    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        resp_pc_d    = resp_pc_q;
        count_d      = count_q;
        discard_d    = discard_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_pc_d    = fifo_pc_q;
        fifo_instr_d = fifo_instr_q;
        inflight_d   = inflight_q + CNT_W'(req_fire_s) - CNT_W'(imem_resp_valid);
        if (redirect_valid) begin
            // Every request still outstanding after this cycle belongs to the old stream.
            count_d    = {CNT_W{1'b0}};
            wr_ptr_d   = {PTR_W{1'b0}};
            rd_ptr_d   = {PTR_W{1'b0}};
            discard_d  = inflight_d;
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            resp_pc_d  = {redirect_pc[31:2], 2'b00};
        end else begin
            if (req_fire_s) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            if (imem_resp_valid && (discard_q != {CNT_W{1'b0}})) begin
                discard_d = discard_q - CNT_W'(1);
            end else begin
                discard_d = discard_q;
            end
            if (keep_s) begin
                resp_pc_d = resp_pc_q + 32'd4;
            end else begin
                resp_pc_d = resp_pc_q;
            end
            if (push_s) begin
                fifo_pc_d[wr_ptr_q]    = resp_pc_q;
                fifo_instr_d[wr_ptr_q] = imem_resp_data;
                wr_ptr_d               = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q   <= RESET_PC;
            resp_pc_q    <= RESET_PC;
            count_q      <= {CNT_W{1'b0}};
            inflight_q   <= {CNT_W{1'b0}};
            discard_q    <= {CNT_W{1'b0}};
            wr_ptr_q     <= {PTR_W{1'b0}};
            rd_ptr_q     <= {PTR_W{1'b0}};
            fifo_pc_q    <= '{default: 32'h0000_0000};
            fifo_instr_q <= '{default: 32'h0000_0000};
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            resp_pc_q    <= resp_pc_d;
            count_q      <= count_d;
            inflight_q   <= inflight_d;
            discard_q    <= discard_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_pc_q    <= fifo_pc_d;
            fifo_instr_q <= fifo_instr_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized bench for instr_fetch_queue: an in-order memory model with variable latency and a
// stream-level reference (expected PC sequence per redirect epoch, held/outstanding counts).
module tb_instr_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam int          CW       = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          imem_req_valid;
    logic          imem_req_ready;
    logic [31:0]   imem_req_addr;
    logic          imem_resp_valid;
    logic [31:0]   imem_resp_data;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic [31:0]   out_pc;
    logic [CW-1:0] inflight_cnt;

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc),
        .inflight_cnt(inflight_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;

    req_t        mq[$];
    int          held;
    int          epoch;
    int          cyc;
    int          lat_lo;
    int          lat_hi;
    logic [31:0] exp_out_pc;
    logic [31:0] exp_req_addr;
    logic        stream_chk;
    int          n_cmp;
    int          n_bad;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", tag, cyc, act, exp);
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst             = 1'b1;
            redirect_valid  = 1'b0;
            redirect_pc     = 32'h0000_0000;
            out_ready       = 1'b1;
            imem_req_ready  = 1'b1;
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0000_0000;
            #1;
            chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_out_pc", out_pc, 32'h0000_0000);
            chk("rst_out_instr", out_instr, 32'h0000_0000);
            chk("rst_inflight", 32'(inflight_cnt), 32'd0);
            @(posedge clk);
            cyc++;
        end
        mq.delete();
        held         = 0;
        epoch        = epoch + 1;
        exp_out_pc   = RESET_PC;
        exp_req_addr = RESET_PC;
    endtask

    task automatic cycle(input logic rv, input logic [31:0] rpc, input logic ordy, input logic qrdy);
        logic        exp_ov;
        logic        exp_rq;
        logic        got_rq;
        logic [31:0] got_addr;
        logic        rsp;
        req_t        e;
        @(negedge clk);
        rst            = 1'b0;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = ordy;
        imem_req_ready = qrdy;
        rsp            = (mq.size() > 0) && (mq[0].due <= cyc);
        imem_resp_valid = rsp;
        imem_resp_data  = rsp ? mem_word(mq[0].addr) : $urandom;
        #1;
        exp_ov = (held > 0) && !rv;
        exp_rq = !rv && ((held + mq.size()) < DEPTH);
        chk("req_valid", 32'(imem_req_valid), 32'(exp_rq));
        chk("out_valid", 32'(out_valid), 32'(exp_ov));
        chk("inflight", 32'(inflight_cnt), 32'(mq.size()));
        if (stream_chk) begin
            chk("throughput", 32'(out_valid), 32'd1);
        end
        if (exp_ov) begin
            chk("out_pc", out_pc, exp_out_pc);
            chk("out_instr", out_instr, mem_word(exp_out_pc));
        end else begin
            chk("idle_pc", out_pc, 32'h0000_0000);
            chk("idle_instr", out_instr, 32'h0000_0000);
        end
        if (imem_req_valid) begin
            chk("req_addr", imem_req_addr, exp_req_addr);
        end
        got_rq   = imem_req_valid;
        got_addr = imem_req_addr;
        @(posedge clk);
        if (rsp) begin
            e = mq.pop_front();
            if (!rv && (e.epoch == epoch)) begin
                held++;
            end
        end
        if (exp_ov && ordy) begin
            held--;
            exp_out_pc = exp_out_pc + 32'd4;
        end
        if (got_rq && qrdy) begin
            mq.push_back('{addr: got_addr, epoch: epoch, due: cyc + $urandom_range(lat_hi, lat_lo)});
            exp_req_addr = exp_req_addr + 32'd4;
        end
        if (rv) begin
            epoch++;
            held         = 0;
            exp_out_pc   = {rpc[31:2], 2'b00};
            exp_req_addr = {rpc[31:2], 2'b00};
        end
        cyc++;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0; epoch = 0; held = 0;
        lat_lo = 1; lat_hi = 1; stream_chk = 1'b0;
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0000_0000;
        out_ready = 1'b1; imem_req_ready = 1'b1;
        imem_resp_valid = 1'b0; imem_resp_data = 32'h0000_0000;
        do_reset(3);

        // Streaming with single-cycle memory: one instruction per cycle once filled.
        for (int i = 0; i < 30; i++) begin
            stream_chk = (i >= 3);
            cycle(1'b0, 32'h0, 1'b1, 1'b1);
        end
        stream_chk = 1'b0;

        // Backpressure: fill to DEPTH, then drain in order.
        do_reset(2);
        repeat (10) cycle(1'b0, 32'h0, 1'b0, 1'b1);
        chk("bp_stall", 32'(imem_req_valid), 32'd0);
        repeat (12) cycle(1'b0, 32'h0, 1'b1, 1'b1);

        // Redirect with two requests in flight at latency 3.
        do_reset(1);
        lat_lo = 3; lat_hi = 3;
        repeat (2) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        cycle(1'b1, 32'h0000_4000, 1'b1, 1'b1);
        repeat (20) cycle(1'b0, 32'h0, 1'b1, 1'b1);

        // Misaligned redirect, then redirect during pop and response, then wrap.
        lat_lo = 1; lat_hi = 1;
        cycle(1'b1, 32'h0000_4003, 1'b1, 1'b1);
        repeat (10) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        cycle(1'b1, 32'h0000_5000, 1'b1, 1'b1);
        repeat (6) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        cycle(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
        repeat (10) cycle(1'b0, 32'h0, 1'b1, 1'b1);

        // Random traffic with variable latency, stalls, redirects and occasional resets.
        lat_lo = 1; lat_hi = 4;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset(1 + $urandom_range(0, 1));
            end else begin
                cycle($urandom_range(0, 15) == 0, $urandom,
                      $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
